// File: rtl/fetch_stage.sv
// Fetch stage: owns the fetch PC, requests one aligned 8-byte block per cycle and unpacks hits into
// INST_PACKETs {valid, inst, pc, npc} (97 bits, slot 0 oldest). Optional counters under FETCH_STATS_EN.
`ifndef INST_BUFF_DEPTH
`define INST_BUFF_DEPTH 8
`endif

module fetch_stage #(
    parameter int          FETCH_WIDTH = 2,
    parameter int          DEPTH       = `INST_BUFF_DEPTH,
    parameter logic [31:0] RESET_PC    = 32'h0,
    localparam int         PKT_W       = 97,
    localparam int         OE_W        = $clog2(DEPTH + 1),
    localparam int         NO_W        = $clog2(FETCH_WIDTH + 1)
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         br_en,
    input  logic [31:0]                  br_target,
    input  logic [OE_W-1:0]              open_entries,
    input  logic                         icache_hit,
    input  logic [63:0]                  icache_data,
    output logic                         icache_req,
    output logic [31:0]                  icache_addr,
    output logic [FETCH_WIDTH*PKT_W-1:0] out_insts,
    output logic [NO_W-1:0]              num_out,
    output logic [31:0]                  fetch_pc,
`ifdef FETCH_STATS_EN
    output logic [31:0]                  stat_fetched,
    output logic [31:0]                  stat_miss_cycles,
    output logic [31:0]                  stat_stall_cycles,
`endif
    output logic [1:0]                   state_dbg
);

    typedef enum logic [1:0] {
        S_FETCH = 2'd0,
        S_MISS  = 2'd1,
        S_STALL = 2'd2
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;

    logic [31:0]     block_base;
    logic [NO_W-1:0] slots_needed;
    logic            fits;

    always_ff @(posedge clock) begin
        state_q <= state_d;
        pc_q    <= pc_d;
    end

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        icache_req   = 1'b0;
        icache_addr  = 32'h0;
        num_out      = '0;
        out_insts    = '0;
        block_base   = {pc_q[31:3], 3'b000};
        // A block entered at its upper word only carries one instruction.
        slots_needed = pc_q[2] ? NO_W'(1) : NO_W'(2);
        fits         = ({{(32-OE_W){1'b0}}, open_entries} >= {{(32-NO_W){1'b0}}, slots_needed});

        if (reset) begin
            pc_d    = RESET_PC;
            state_d = S_FETCH;
        end else if (br_en) begin
            pc_d    = br_target & ~32'h3;
            state_d = S_FETCH;
        end else begin
            icache_req  = 1'b1;
            icache_addr = block_base;
            if (icache_hit && fits) begin
                num_out = slots_needed;
                if (pc_q[2]) begin
                    out_insts[PKT_W-1:0] = {1'b1, icache_data[63:32], block_base + 32'd4, block_base + 32'd8};
                end else begin
                    out_insts[PKT_W-1:0]         = {1'b1, icache_data[31:0], block_base, block_base + 32'd4};
                    out_insts[2*PKT_W-1:PKT_W]   = {1'b1, icache_data[63:32], block_base + 32'd4, block_base + 32'd8};
                end
                pc_d    = block_base + 32'd8;
                state_d = S_FETCH;
            end else if (!icache_hit) begin
                state_d = S_MISS;
            end else begin
                // Whole block or nothing: no partial emission when the buffer is short.
                state_d = S_STALL;
            end
        end
    end

    assign fetch_pc  = pc_q;
    assign state_dbg = state_q;

`ifdef FETCH_STATS_EN
    logic [31:0] stat_fetched_q, stat_fetched_d;
    logic [31:0] stat_miss_q, stat_miss_d;
    logic [31:0] stat_stall_q, stat_stall_d;
    logic [32:0] fetched_sum;

    always_ff @(posedge clock) begin
        stat_fetched_q <= stat_fetched_d;
        stat_miss_q    <= stat_miss_d;
        stat_stall_q   <= stat_stall_d;
    end

    always_comb begin
        stat_fetched_d = stat_fetched_q;
        stat_miss_d    = stat_miss_q;
        stat_stall_d   = stat_stall_q;
        fetched_sum    = {1'b0, stat_fetched_q} + 33'(num_out);
        if (reset) begin
            stat_fetched_d = '0;
            stat_miss_d    = '0;
            stat_stall_d   = '0;
        end else begin
            stat_fetched_d = fetched_sum[32] ? 32'hFFFF_FFFF : fetched_sum[31:0];
            if (icache_req && !icache_hit && stat_miss_q != 32'hFFFF_FFFF)
                stat_miss_d = stat_miss_q + 32'd1;
            if (icache_req && icache_hit && !fits && stat_stall_q != 32'hFFFF_FFFF)
                stat_stall_d = stat_stall_q + 32'd1;
        end
    end

    assign stat_fetched      = stat_fetched_q;
    assign stat_miss_cycles  = stat_miss_q;
    assign stat_stall_cycles = stat_stall_q;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed scenarios then random traffic, scoreboarded against a reference PC/state model.
module tb_fetch_stage;

  localparam int PKT_W = 97;
  localparam int EW    = 2 + 1 + 32 + 2 + 32 + 2*PKT_W;

  logic              clock;
  logic              reset;
  logic              br_en;
  logic [31:0]       br_target;
  logic [3:0]        open_entries;
  logic              icache_hit;
  logic [63:0]       icache_data;
  logic              icache_req;
  logic [31:0]       icache_addr;
  logic [2*PKT_W-1:0] out_insts;
  logic [1:0]        num_out;
  logic [31:0]       fetch_pc;
  logic [1:0]        state_dbg;
`ifdef FETCH_STATS_EN
  logic [31:0]       stat_fetched;
  logic [31:0]       stat_miss_cycles;
  logic [31:0]       stat_stall_cycles;
`endif

  fetch_stage #(.FETCH_WIDTH(2), .DEPTH(8), .RESET_PC(32'h0)) dut (
    .clock(clock),
    .reset(reset),
    .br_en(br_en),
    .br_target(br_target),
    .open_entries(open_entries),
    .icache_hit(icache_hit),
    .icache_data(icache_data),
    .icache_req(icache_req),
    .icache_addr(icache_addr),
    .out_insts(out_insts),
    .num_out(num_out),
    .fetch_pc(fetch_pc),
`ifdef FETCH_STATS_EN
    .stat_fetched(stat_fetched),
    .stat_miss_cycles(stat_miss_cycles),
    .stat_stall_cycles(stat_stall_cycles),
`endif
    .state_dbg(state_dbg)
  );

  // clock / reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  int errors = 0;
  int checks = 0;

  logic [EW-1:0] exp_q[$];

  logic [31:0] m_pc;
  logic [1:0]  m_state;
  logic [31:0] m_fetched, m_miss, m_stall;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [PKT_W-1:0] mk_pkt(input logic [31:0] inst, input logic [31:0] pc);
    return {1'b1, inst, pc, pc + 32'd4};
  endfunction

  // driver: one cycle of stimulus, expected outputs pushed, compared at the falling edge
  task automatic step(input logic rst, input logic br, input logic [31:0] tgt,
                      input logic hit, input logic [63:0] data, input logic [3:0] open);
    logic [EW-1:0]      e;
    logic [31:0]        base;
    logic [1:0]         nv;
    logic               emit;
    logic               req;
    logic [31:0]        addr;
    logic [1:0]         num;
    logic [2*PKT_W-1:0] slots;
    reset        = rst;
    br_en        = br;
    br_target    = tgt;
    icache_hit   = hit;
    icache_data  = data;
    open_entries = open;

    base  = {m_pc[31:3], 3'b000};
    nv    = m_pc[2] ? 2'd1 : 2'd2;
    req   = !rst && !br;
    emit  = req && hit && ({2'b00, nv} <= open);
    addr  = req ? base : 32'h0;
    num   = emit ? nv : 2'd0;
    slots = '0;
    if (emit) begin
      if (m_pc[2]) begin
        slots[PKT_W-1:0] = mk_pkt(data[63:32], base + 32'd4);
      end else begin
        slots[PKT_W-1:0]       = mk_pkt(data[31:0], base);
        slots[2*PKT_W-1:PKT_W] = mk_pkt(data[63:32], base + 32'd4);
      end
    end
    exp_q.push_back({m_state, req, addr, num, m_pc, slots});

    @(negedge clock);
    if (exp_q.size() == 0) begin
      check("queue_empty", 128'd1, 128'd0);
    end else begin
      e = exp_q.pop_front();
      check("state",     {126'd0, state_dbg},        {126'd0, e[EW-1 -: 2]});
      check("icache_req", {127'd0, icache_req},      {127'd0, e[EW-3]});
      check("icache_addr", {96'd0, icache_addr},     {96'd0, e[EW-4 -: 32]});
      check("num_out",   {126'd0, num_out},          {126'd0, e[EW-36 -: 2]});
      check("fetch_pc",  {96'd0, fetch_pc},          {96'd0, e[EW-38 -: 32]});
      check("slot0",     {31'd0, out_insts[PKT_W-1:0]}, {31'd0, e[PKT_W-1:0]});
      check("slot1",     {31'd0, out_insts[2*PKT_W-1:PKT_W]}, {31'd0, e[2*PKT_W-1:PKT_W]});
    end
`ifdef FETCH_STATS_EN
    check("stat_fetched", {96'd0, stat_fetched},      {96'd0, m_fetched});
    check("stat_miss",    {96'd0, stat_miss_cycles},  {96'd0, m_miss});
    check("stat_stall",   {96'd0, stat_stall_cycles}, {96'd0, m_stall});
`endif

    if (rst) begin
      m_pc = 32'h0;
      m_state = 2'd0;
      m_fetched = 0; m_miss = 0; m_stall = 0;
    end else if (br) begin
      m_pc = {tgt[31:2], 2'b00};
      m_state = 2'd0;
    end else if (emit) begin
      m_pc = base + 32'd8;
      m_state = 2'd0;
      m_fetched = m_fetched + {30'd0, num};
    end else if (!hit) begin
      m_state = 2'd1;
      m_miss = m_miss + 1;
    end else begin
      m_state = 2'd2;
      m_stall = m_stall + 1;
    end

    @(posedge clock);
    #1;
  endtask

  localparam logic [63:0] DATA_AB = 64'hBBBB_BBBB_AAAA_AAAA;

`ifdef FETCH_STATS_EN
  logic [31:0] snap;
`endif

  initial begin
    reset = 1'b1; br_en = 1'b0; br_target = 32'h0;
    icache_hit = 1'b1; icache_data = DATA_AB; open_entries = 4'd8;
    // first reset cycle: registered state unknown, only gated outputs checked
    @(negedge clock);
    check("rst_req",   {127'd0, icache_req}, 128'd0);
    check("rst_num",   {126'd0, num_out},    128'd0);
    check("rst_insts", {{(128-PKT_W){1'b0}}, out_insts[PKT_W-1:0]}, 128'd0);
    @(posedge clock); #1;
    m_pc = 32'h0; m_state = 2'd0; m_fetched = 0; m_miss = 0; m_stall = 0;
    // reset and br_en together: reset wins
    step(1'b1, 1'b1, 32'h500, 1'b1, DATA_AB, 4'd8);

    // straight-line fetch from 0
    step(1'b0, 1'b0, 32'h0, 1'b1, DATA_AB, 4'd8);
    step(1'b0, 1'b0, 32'h0, 1'b1, DATA_AB, 4'd8);

    // squash to 0x104 (hit ignored on the squash cycle), then upper-word-only block
    step(1'b0, 1'b1, 32'h104, 1'b1, DATA_AB, 4'd8);
    step(1'b0, 1'b0, 32'h0, 1'b1, 64'h1111_2222_3333_4444, 4'd8);

    // three miss cycles at 0x40, then the hit
    step(1'b0, 1'b1, 32'h43, 1'b0, 64'h0, 4'd8);
`ifdef FETCH_STATS_EN
    snap = stat_miss_cycles;
`endif
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 32'h0, 1'b0, 64'h0, 4'd8);
`ifdef FETCH_STATS_EN
    check("miss_delta", {96'd0, stat_miss_cycles - snap}, 128'd3);
`endif
    step(1'b0, 1'b0, 32'h0, 1'b1, 64'h5555_5555_6666_6666, 4'd8);
    step(1'b0, 1'b0, 32'h0, 1'b0, 64'h0, 4'd8);

    // stall at 0x20 with one free entry, then room for two; zero room never emits
    step(1'b0, 1'b1, 32'h20, 1'b1, DATA_AB, 4'd8);
`ifdef FETCH_STATS_EN
    snap = stat_stall_cycles;
`endif
    step(1'b0, 1'b0, 32'h0, 1'b1, DATA_AB, 4'd1);
`ifdef FETCH_STATS_EN
    check("stall_delta", {96'd0, stat_stall_cycles - snap}, 128'd1);
`endif
    step(1'b0, 1'b0, 32'h0, 1'b1, DATA_AB, 4'd2);
    step(1'b0, 1'b1, 32'h24, 1'b1, DATA_AB, 4'd8);
    step(1'b0, 1'b0, 32'h0, 1'b1, DATA_AB, 4'd0);
    step(1'b0, 1'b0, 32'h0, 1'b1, DATA_AB, 4'd1);

    // wrap from the top of the address space
    step(1'b0, 1'b1, 32'hFFFF_FFF8, 1'b1, DATA_AB, 4'd8);
    step(1'b0, 1'b0, 32'h0, 1'b1, 64'h7777_7777_8888_8888, 4'd8);
    step(1'b0, 1'b0, 32'h0, 1'b1, DATA_AB, 4'd8);

    // random traffic
    for (int i = 0; i < 300; i++) begin
      step($urandom_range(0, 63) == 0,
           $urandom_range(0, 15) == 0,
           $urandom,
           $urandom_range(0, 3) != 0,
           {$urandom, $urandom},
           4'($urandom_range(0, 8)));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Front-end fetch stage that feeds the instruction buffer. Owns the fetch PC and issues one aligned 8-byte block request per cycle to the icache.
- Unpacks each returned block into up to FETCH_WIDTH INST_PACKETs, gated by the buffer's free-entry count.
- Redirects to a branch target on squash; the buffer flushes on the same br_en.

Parameters:
- FETCH_WIDTH, 2, instructions per fetch block (block = FETCH_WIDTH*4 bytes; fixed 2 so block = 64 bits).
- DEPTH, `INST_BUFF_DEPTH, instruction-buffer depth; sizes open_entries.
- RESET_PC, 32'h0, PC loaded on reset.

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high reset
- br_en  in  1  branch squash; redirect to br_target
- br_target  in  32  redirect PC
- open_entries  in  $clog2(DEPTH+1)  free buffer entries this cycle
- icache_hit  in  1  icache_data valid for icache_addr this cycle
- icache_data  in  64  instruction block; inst0 = [31:0], inst1 = [63:32]
- icache_req  out  1  icache request valid
- icache_addr  out  32  block address, {pc[31:3],3'b0}
- out_insts  out  INST_PACKET[FETCH_WIDTH-1:0]  packed insts, lowest index oldest
- num_out  out  $clog2(FETCH_WIDTH+1)  count of valid out_insts; drives buffer num_accept
- fetch_pc  out  32  current fetch PC

Behaviour:
- States:
  - FETCH: normal issue.
  - MISS: waiting on icache.
  - STALL: buffer lacks room.
- Reset:
  - pc = RESET_PC, state = FETCH.
  - All outputs 0 that cycle (icache_req = 0, num_out = 0, out_insts = '0).
- icache_req = 1 in FETCH, MISS and STALL, except the reset cycle and any cycle with br_en = 1.
- Slot count: valid = 2 if pc[2] = 0; valid = 1 (upper inst only) if pc[2] = 1.
- Emission, combinational in the same cycle: icache_hit && open_entries >= valid && !br_en.
  - Slot k gets inst, PC, NPC = PC+4, valid = 1. All other fields are '0.
  - Slots with index >= num_out are '0.
  - Next pc = {pc[31:3],3'b0} + 8. Next state = FETCH.
- No hit (and no br_en): num_out = 0, pc held, next state = MISS. Stay in MISS until a hit.
- Hit but open_entries < valid: num_out = 0, pc held, next state = STALL. Re-evaluate every cycle; no partial block emission.
- br_en has highest priority over every state and any hit:
  - num_out = 0, icache_req = 0.
  - Next pc = {br_target[31:2],2'b0}, next state = FETCH.
  - First request to the new PC is issued the following cycle.
- br_en and reset together: reset wins.
- PC arithmetic is 32-bit and wraps modulo 2^32 (32'hFFFF_FFF8 + 8 = 0).
- fetch_pc = registered pc.
- Output timing: num_out/out_insts are combinational from pc, icache_hit, icache_data, open_entries and br_en.
  - Buffer-side latency is 1 cycle (entries are written at the next edge).
- open_entries == 0: never emit. open_entries == 1 with pc[2] = 0: stall.

Optional Feature:
- Macro: FETCH_STATS_EN.
- When defined, adds three 32-bit output ports, each reset to 0 and saturating at 32'hFFFF_FFFF:
  - stat_fetched: += num_out each cycle.
  - stat_miss_cycles: +1 per cycle with icache_req && !icache_hit.
  - stat_stall_cycles: +1 per cycle with a hit but insufficient room.
- When undefined: ports and counters are absent; no behavioural difference otherwise.

Test Plan:
- Reset, RESET_PC = 0, always hit, open_entries = 8, data 64'hBBBB_BBBB_AAAA_AAAA -> cycle 1: icache_addr = 0, num_out = 2, insts AAAA_AAAA@0 and BBBB_BBBB@4; cycle 2: icache_addr = 8.
- br_en with br_target = 32'h104 -> that cycle num_out = 0, icache_req = 0; next cycle icache_addr = 32'h100, num_out = 1, inst = upper word, PC = 32'h104, NPC = 32'h108.
- icache_hit low for 3 cycles at pc = 32'h40 -> state MISS, num_out = 0, icache_addr stays 32'h40; hit on cycle 4 -> num_out = 2, then pc = 32'h48.
- open_entries = 1, pc = 32'h20, hit -> num_out = 0 (STALL), pc held; open_entries = 2 -> num_out = 2.
- pc = 32'hFFFF_FFF8, hit -> emits 2 insts, next icache_addr = 0.
- FETCH_STATS_EN defined, run the miss and stall scenarios -> stat_miss_cycles = 3, stat_stall_cycles = 1, stat_fetched = total of num_out.
